uart_rx_sampler: RTL

Standalone UART receiver clocked directly on the system clock. It derives its own oversample tick, validates the start bit, takes a majority-voted sample at mid-bit, and checks the stop bit. Each received byte is presented on a valid/ready output handshake, with framing-error and overrun reporting. This is the receive-side counterpart used when an external transmitter drives the line, replacing the internal TX-to-RX loopback.

---
 rtl/uart_rx_sampler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART receiver with oversampled majority vote and valid/ready byte output
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx_sampler #(
  parameter int CLOCK_RATE    = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_Rx_Data,
  input  logic       i_Rx_Ready,
  output logic       o_Rx_Valid,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(RX_OVERSAMPLE);
  localparam int M       = RX_OVERSAMPLE / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] CNT_A    = SW'(M - 1);
  localparam logic [SW-1:0] CNT_B    = SW'(M);
  localparam logic [SW-1:0] CNT_RES  = SW'(M + 1);
  localparam logic [SW-1:0] CNT_LAST = SW'(RX_OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_state, w_next;
  logic            r_sync1, r_sync2;
  logic            w_rx;
  logic [DW-1:0]   r_div_cnt;
  logic            w_tick;
  logic [SW-1:0]   r_smp_cnt;
  logic            r_s0, r_s1;
  logic            w_maj, w_res, w_bit_end;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_armed;
  logic            w_restart, w_done, w_ferr, w_clr_arm;
  logic            w_par_bad;
  logic            r_valid, r_ferr, r_ovr;
  logic [7:0]      r_byte;

  assign w_rx      = r_sync2;
  assign w_tick    = (r_div_cnt == DIV_LAST);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_res     = w_tick && (r_smp_cnt == CNT_RES);
  assign w_bit_end = w_tick && (r_smp_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_Rx_Data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // STOP leaves at its resolve point so the next start edge is never missed
  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
    w_clr_arm = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !w_rx) begin
          w_next    = S_START;
          w_restart = 1'b1;
        end
      end
      S_START: begin
        if (w_res && w_maj)  w_next = S_IDLE;
        else if (w_bit_end)  w_next = S_DATA;
      end
      S_DATA: begin
`ifdef UART_RX_PARITY_EN
        if (w_bit_end && r_bit_idx == 3'd7) w_next = S_PARITY;
`else
        if (w_bit_end && r_bit_idx == 3'd7) w_next = S_STOP;
`endif
      end
      S_PARITY: begin
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_res) begin
          w_next = S_IDLE;
          if (!w_maj) begin
            w_ferr    = 1'b1;
            w_clr_arm = 1'b1;
          end else if (w_par_bad) begin
            w_ferr = 1'b1;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_bad = r_par_bad;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_par_bad <= 1'b0;
    else if (r_state == S_PARITY && w_res) r_par_bad <= w_maj ^ (^r_shift);
  end
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_smp_cnt <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b1;
    end else begin
      if (w_restart || w_tick) r_div_cnt <= '0;
      else                     r_div_cnt <= r_div_cnt + 1'b1;

      if (r_state == S_IDLE) r_smp_cnt <= '0;
      else if (w_tick)       r_smp_cnt <= (r_smp_cnt == CNT_LAST) ? '0 : r_smp_cnt + 1'b1;

      if (w_tick && r_smp_cnt == CNT_A) r_s0 <= w_rx;
      if (w_tick && r_smp_cnt == CNT_B) r_s1 <= w_rx;

      if (r_state != S_DATA) r_bit_idx <= '0;
      else if (w_bit_end)    r_bit_idx <= r_bit_idx + 1'b1;

      if (r_state == S_DATA && w_res) r_shift[r_bit_idx] <= w_maj;

      // a low stop bit (framing error or break) must see idle high before re-arming
      if (w_clr_arm)                       r_armed <= 1'b0;
      else if (r_state == S_IDLE && w_rx)  r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_byte  <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_done) begin
        if (!r_valid || i_Rx_Ready) begin
          r_byte  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && i_Rx_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_Rx_Valid  = r_valid;
  assign o_Rx_Byte   = r_byte;
  assign o_Frame_Err = r_ferr;
  assign o_Overrun   = r_ovr;

endmodule
